mod_updown_counter: RTL
=======================

Name: mod_updown_counter

Overview:
Parametrised loadable up/down modulo counter with runtime modulus and selectable end-of-count mode: wrap, saturate or one-shot. It is the successor to the team's fixed 8-bit up-only load counter. It adds direction control, count enable, cascade carry, a wrap strobe and a one-shot done state machine. It is used for timers, dividers and event counters in datapath control.

Parameters:
WIDTH, 8, counter, load_value and mod_value width in bits (2..32)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
en  input  1  count enable; one step per cycle while high
load  input  1  load load_value into count
load_value  input  WIDTH  value to load; clamped to modulus range
mod_value  input  WIDTH  modulus M; count range is 0..M-1; 0 means 2^WIDTH
dir  input  1  1 = up, 0 = down
mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 reserved (acts as wrap)
count  output  WIDTH  current count, registered
carry_out  output  1  combinational: en & (count == terminal) & state==RUN; used for cascading
wrap  output  1  registered one-cycle pulse; count wrapped on the previous edge
done  output  1  registered; high while in DONE state

Behaviour:
- Reset (rst=1 at edge): count=0, wrap=0, done=0, state=RUN. rst overrides all other inputs. Reset mid-count or mid-DONE returns to these values in 1 cycle.
- Priority at each edge: rst > load > en.
- Terminal value: up = M-1 (all ones when M==0); down = 0. Arithmetic is WIDTH bits. The M-1 computation wraps naturally for M==0.
- load: count <= (M!=0 && load_value>=M) ? M-1 : load_value. State goes to RUN, done=0, wrap=0. load with en=1 loads only; no step that cycle.
- States:
  - RUN: counting allowed.
  - DONE: reached only in one-shot mode. count holds and en is ignored. Exit on load or rst only.
- RUN with en=1, count != terminal: count +/- 1 per dir.
- RUN with en=1, count == terminal:
  - wrap mode: count <= (up ? 0 : M-1), wrap=1 next cycle.
  - saturate mode: count holds, wrap=0.
  - one-shot mode: count holds, state <= DONE, done=1 from next cycle.
- en=0: count holds, wrap=0.
- Out-of-range count (mod_value lowered below current count) with en=1:
  - up: count <= 0. This is treated as a wrap, so wrap=1 in wrap mode.
  - down: count <= M-1, wrap=0.
- dir or mode change mid-count takes effect on the next enabled step. No state is flushed. Changing mode while in DONE does not leave DONE.
- M==1: count fixed at 0. In wrap mode every enabled cycle pulses wrap.
- Latency: count updates 1 cycle after the enabling edge. wrap and done are aligned to the same edge as the count update that caused them.
- carry_out is purely combinational from registered count and current inputs; no register stage.

Decomposition:
- Package mod_counter_pkg:
  - typedef enum logic [1:0] mode_e {MODE_WRAP=2'b00, MODE_SAT=2'b01, MODE_ONESHOT=2'b10, MODE_RSVD=2'b11}.
  - typedef enum logic state_e {ST_RUN, ST_DONE}.
  - Function for terminal-value computation.
- One combinational sub-module, mod_counter_next: takes count, M, dir, mode and returns next_count, at_terminal, wrap_event. The top holds the registers and the FSM.

Test Plan:
1. Reset/load clamp: rst=1 then 0; WIDTH=8, M=18, load_value=25 -> count=17 next cycle, wrap=0, done=0.
2. Wrap up: M=18, load 5, dir=1, en=1, mode=00 -> counts 5..17, then 0 with wrap=1 exactly on the cycle count shows 0; carry_out=1 while count=17.
3. Down saturate: M=10, load 3, dir=0, mode=01, en=1 -> 2,1,0, then holds 0 for 5 cycles; wrap never asserts.
4. One-shot: M=6, load 0, up, mode=10 -> reaches 5, done=1 next cycle, count stays 5 despite en=1. load 2 -> done=0, count=2, counting resumes.
5. Modulus shrink and M=0: count=15 with M=20, set M=8, en=1 up -> count=0, wrap=1. Separately, M=0, load 254, up -> 255, then 0 with wrap=1.
6. Priority and reset mid-op: in DONE, assert rst with load=1 -> count=0, done=0. In RUN, load=1 with en=1, load_value=4 -> count=4, no increment.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared types and helpers for the modulo up/down counter.
package mod_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic {ST_RUN, ST_DONE} state_e;

  // Computed at 32 bits; the caller truncates, so m==0 yields all ones.
  function automatic logic [31:0] terminal_val(input logic [31:0] m, input logic up);
    return up ? (m - 32'd1) : 32'd0;
  endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count logic: one enabled step of the modulo counter.
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] m,
  input  logic             dir,
  input  mode_e            mode,
  output logic [WIDTH-1:0] next_count,
  output logic             at_terminal,
  output logic             wrap_event
);

  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] m_last;
  logic             oor;
  logic             wrap_mode;

  assign term        = WIDTH'(terminal_val(32'(m), dir));
  assign m_last      = m - WIDTH'(1);
  assign oor         = (m != '0) && (count >= m);
  assign wrap_mode   = (mode == MODE_WRAP) || (mode == MODE_RSVD);
  assign at_terminal = (count == term);

  always_comb begin
    next_count = count;
    wrap_event = 1'b0;
    if (oor) begin
      // Modulus shrank under the count: up folds to 0 as a wrap, down re-enters at the top.
      if (dir) begin
        next_count = '0;
        wrap_event = wrap_mode;
      end else begin
        next_count = m_last;
      end
    end else if (at_terminal) begin
      if (wrap_mode) begin
        next_count = dir ? '0 : m_last;
        wrap_event = 1'b1;
      end
    end else begin
      next_count = dir ? count + WIDTH'(1) : count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Loadable up/down modulo counter with wrap, saturate and one-shot end-of-count modes.
module mod_updown_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] mod_value,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic             wrap,
  output logic             done
);

  state_e           state;
  mode_e            mode_q;
  logic [WIDTH-1:0] next_count;
  logic [WIDTH-1:0] load_clamped;
  logic             at_terminal;
  logic             wrap_event;

  assign mode_q = mode_e'(mode);

  mod_counter_next #(.WIDTH(WIDTH)) u_next (
    .count       (count),
    .m           (mod_value),
    .dir         (dir),
    .mode        (mode_q),
    .next_count  (next_count),
    .at_terminal (at_terminal),
    .wrap_event  (wrap_event)
  );

  assign load_clamped = ((mod_value != '0) && (load_value >= mod_value))
                        ? mod_value - WIDTH'(1) : load_value;

  assign carry_out = en & at_terminal & (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
      done  <= 1'b0;
      state <= ST_RUN;
    end else if (load) begin
      count <= load_clamped;
      wrap  <= 1'b0;
      done  <= 1'b0;
      state <= ST_RUN;
    end else if (en && state == ST_RUN) begin
      count <= next_count;
      wrap  <= wrap_event;
      if (at_terminal && mode_q == MODE_ONESHOT) begin
        state <= ST_DONE;
        done  <= 1'b1;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule
